image_loader: RTL and testbench

Upstream feeder for the image-processor core: accepts an 8-bit pixel byte stream over a valid/ready handshake, packs four bytes per 32-bit word, and writes the words into data memory through the dmem write port ahead of the processor. While loading, it holds the processor in reset via `proc_hold`. It releases the processor once the configured image size has been written.

---
 rtl/image_pkg.sv | 17 +
 rtl/byte_packer.sv | 56 +++++
 rtl/image_loader.sv | 146 ++++++++++++++
 tb/tb_image_loader.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// image_pkg: definitions shared by the image loader and its byte packer.
//   state_e    - loader FSM encoding (IDLE, LOAD, FLUSH, DONE)
//   LANE_W     - width of the byte-lane counter (four lanes per 32-bit word)
//   DEF_ADDR_W - default dmem word-address width
package image_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int LANE_W     = 2;
    localparam int DEF_ADDR_W = 12;

endpackage

// File: rtl/byte_packer.sv
// byte_packer: assembles four accepted bytes into one little-endian 32-bit word.
// Ports:
//   clock       - system clock, rising edge
//   reset       - asynchronous active-low reset
//   clear_i     - restart packing at lane 0 (takes priority over accept_i)
//   accept_i    - a byte is consumed this cycle
//   byte_i      - byte to place in the current lane
//   word_o      - packed word including the byte being accepted this cycle
//   word_full_o - high in the cycle the lane-3 byte is accepted
module byte_packer
    import image_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [31:0]       data_q, data_d;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        lane_d = lane_q;
        data_d = data_q;
        if (clear_i) begin
            lane_d = '0;
            data_d = '0;
        end else if (accept_i) begin
            lane_d                 = lane_q + 1'b1;  // wraps 3 -> 0 after a full word
            data_d[8*lane_q +: 8]  = byte_i;
        end
    end

    // The packed word is taken from the next-state value so the owner can
    // register it on the same edge that accepts the last byte.
    assign word_o      = data_d;
    assign word_full_o = accept_i && !clear_i && (lane_q == '1);

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the values from before the edge.
        if (!reset) begin
            lane_q <= '0;
            data_q <= '0;
        end else begin
            lane_q <= lane_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/image_loader.sv
// image_loader: receives a valid/ready pixel byte stream, packs four bytes per
// 32-bit word and writes the words into dmem from BASE_ADDR upward while
// holding the processor in reset. The processor is released once IMG_WORDS
// words have been written.
// Optional feature: define IMAGE_LOADER_CHECKSUM_EN to build a running modulo
// 2^32 sum of written words on `checksum`; otherwise `checksum` is tied to 0.
// Ports:
//   clock, reset       - clock (rising edge), asynchronous active-low reset
//   start              - one-cycle pulse beginning a load (honoured in IDLE/DONE)
//   in_valid, in_data  - byte stream input
//   in_ready           - byte accepted when in_valid && in_ready
//   dmem_addr/data/wren- dmem write port, wren pulses once per word
//   proc_hold          - processor held in reset while high
//   done               - image complete, held until the next start
//   word_count         - words written since start
//   checksum           - running word sum (macro builds only)
module image_loader
    import image_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BASE_ADDR = 0,
    parameter int IMG_WORDS = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_data,
    output logic              dmem_wren,
    output logic              proc_hold,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic [31:0]       checksum
);

    localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   LAST_COUNT = (ADDR_W+1)'(IMG_WORDS);

    state_e            state_q;
    logic              in_ready_q;
    logic              dmem_wren_q;
    logic              proc_hold_q;
    logic              done_q;
    logic [ADDR_W-1:0] dmem_addr_q;
    logic [31:0]       dmem_data_q;
    logic [ADDR_W:0]   word_count_q;

    logic              accept;
    logic              launch;
    logic              word_full;
    logic [31:0]       packed_word;
    logic [ADDR_W:0]   word_count_inc;

    // in_ready is only high in LOAD, so bytes offered elsewhere are never consumed.
    assign accept         = in_valid && in_ready_q;
    assign launch         = start && ((state_q == IDLE) || (state_q == DONE));
    assign word_count_inc = word_count_q + 1'b1;

    byte_packer u_packer (
        .clock       (clock),
        .reset       (reset),
        .clear_i     (launch),
        .accept_i    (accept),
        .byte_i      (in_data),
        .word_o      (packed_word),
        .word_full_o (word_full)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            dmem_wren_q  <= 1'b0;
            proc_hold_q  <= 1'b1;
            done_q       <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_data_q  <= '0;
            word_count_q <= '0;
        end else begin
            dmem_wren_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q      <= LOAD;
                        in_ready_q   <= 1'b1;
                        proc_hold_q  <= 1'b1;
                        done_q       <= 1'b0;
                        word_count_q <= '0;
                    end
                end
                LOAD: begin
                    if (word_full) begin
                        state_q     <= FLUSH;
                        in_ready_q  <= 1'b0;
                        dmem_wren_q <= 1'b1;
                        dmem_addr_q <= BASE + word_count_q[ADDR_W-1:0];
                        dmem_data_q <= packed_word;
                    end
                end
                FLUSH: begin
                    word_count_q <= word_count_inc;
                    if (word_count_inc == LAST_COUNT) begin
                        state_q     <= DONE;
                        done_q      <= 1'b1;
                        proc_hold_q <= 1'b0;
                    end else begin
                        state_q    <= LOAD;
                        in_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign dmem_wren  = dmem_wren_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_data  = dmem_data_q;
    assign proc_hold  = proc_hold_q;
    assign done       = done_q;
    assign word_count = word_count_q;

`ifdef IMAGE_LOADER_CHECKSUM_EN
    logic [31:0] checksum_q;

    // The word being written is already in dmem_data_q during FLUSH.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            checksum_q <= '0;
        end else if (launch) begin
            checksum_q <= '0;
        end else if (state_q == FLUSH) begin
            checksum_q <= checksum_q + dmem_data_q;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_image_loader.sv
// tb_image_loader: randomized self-checking bench for image_loader.
// A monitor logs every dmem write; expected words, addresses, latency and
// checksum come from a packing model computed directly from the byte list.
module tb_image_loader;

    localparam int ADDR_W    = 12;
    localparam int BASE_ADDR = 16;
    localparam int IMG_WORDS = 2;

    logic              clock    = 1'b0;
    logic              reset    = 1'b0;
    logic              start    = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data  = 8'h00;
    logic              in_ready;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_data;
    logic              dmem_wren;
    logic              proc_hold;
    logic              done;
    logic [ADDR_W:0]   word_count;
    logic [31:0]       checksum;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit tog    = 1'b0;

    // Monitor log (written only by the monitor).
    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];
    int                wr_cyc[$];
    logic [2:0]        wr_flags[$];   // {in_ready, proc_hold, done} during the write
    int                done_rise_cyc = -1;
    logic              done_prev     = 1'b0;

    // Edge on which the last byte of each word was accepted (driver side).
    int acc_cyc[$];

    image_loader #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .IMG_WORDS (IMG_WORDS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .dmem_addr  (dmem_addr),
        .dmem_data  (dmem_data),
        .dmem_wren  (dmem_wren),
        .proc_hold  (proc_hold),
        .done       (done),
        .word_count (word_count),
        .checksum   (checksum)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset === 1'b1 && dmem_wren === 1'b1) begin
            wr_addr.push_back(dmem_addr);
            wr_data.push_back(dmem_data);
            wr_cyc.push_back(cyc);
            wr_flags.push_back({in_ready, proc_hold, done});
        end
        if (done === 1'b1 && done_prev !== 1'b1) done_rise_cyc = cyc;
        done_prev = done;
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] word_of(input logic [7:0] img[$], input int w);
        return {img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]};
    endfunction

    function automatic logic [31:0] exp_checksum(input logic [7:0] img[$]);
        logic [31:0] s = 32'd0;
        for (int w = 0; w < img.size() / 4; w++) s += word_of(img, w);
`ifdef IMAGE_LOADER_CHECKSUM_EN
        return s;
`else
        return 32'd0;
`endif
    endfunction

    function automatic void rand_image(output logic [7:0] img[$]);
        img = {};
        for (int i = 0; i < 4 * IMG_WORDS; i++) img.push_back(8'($urandom));
    endfunction

    // ---------------- stimulus helpers (start/end just after a rising edge) ----------------
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
    endtask

    // mode 0: continuous valid, 1: valid toggles every cycle, 2: random gaps
    task automatic send_bytes(input logic [7:0] img[$], input int first, input int last,
                              input int mode, output bit to);
        bit v, rdy, taken;
        int budget;
        to = 1'b0;
        for (int i = first; i <= last; i++) begin
            taken  = 1'b0;
            budget = 100;
            while (!taken && !to) begin
                case (mode)
                    0:       v = 1'b1;
                    1:       begin v = tog; tog = ~tog; end
                    default: v = ($urandom_range(0, 2) != 0);
                endcase
                in_valid = v;
                in_data  = v ? img[i] : 8'($urandom);
                @(negedge clock);
                rdy = in_ready;
                next_cycle();
                if (v && rdy) begin
                    taken = 1'b1;
                    if (i % 4 == 3) acc_cyc.push_back(cyc);
                end else begin
                    budget--;
                    if (budget == 0) to = 1'b1;
                end
            end
            if (to) break;
        end
        in_valid = 1'b0;
    endtask

    // Ends half a cycle after the edge on which done was seen.
    task automatic wait_done(output bit to);
        int budget = 40;
        to = 1'b0;
        while (done !== 1'b1 && budget > 0) begin
            next_cycle();
            budget--;
        end
        if (done !== 1'b1) to = 1'b1;
        @(negedge clock);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        start    = 1'b0;
        repeat (3) next_cycle();
        checks++;
        if ({in_ready, dmem_wren, proc_hold, done} !== 4'b0010 || dmem_addr !== '0 ||
            dmem_data !== 32'd0 || word_count !== '0 || checksum !== 32'd0) begin
            errors++;
            $display("FAIL reset_held got rdy=%b wren=%b hold=%b done=%b addr=%h data=%h cnt=%0d sum=%h want 0 0 1 0 0 0 0 0",
                     in_ready, dmem_wren, proc_hold, done, dmem_addr, dmem_data, word_count, checksum);
        end
        reset = 1'b1;
        repeat (2) next_cycle();
        checks++;
        if ({in_ready, dmem_wren, proc_hold, done} !== 4'b0010 || dmem_addr !== '0 ||
            dmem_data !== 32'd0 || word_count !== '0 || checksum !== 32'd0) begin
            errors++;
            $display("FAIL reset_released got rdy=%b wren=%b hold=%b done=%b addr=%h data=%h cnt=%0d sum=%h want 0 0 1 0 0 0 0 0",
                     in_ready, dmem_wren, proc_hold, done, dmem_addr, dmem_data, word_count, checksum);
        end
    endtask

    task automatic test_idle_ignore();
        int base = wr_addr.size();
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks++;
            if (in_ready !== 1'b0 || dmem_wren !== 1'b0 || proc_hold !== 1'b1) begin
                errors++;
                $display("FAIL idle_valid cycle %0d got rdy=%b wren=%b hold=%b want 0 0 1",
                         i, in_ready, dmem_wren, proc_hold);
            end
            next_cycle();
        end
        in_valid = 1'b0;
        checks++;
        if (wr_addr.size() !== base) begin
            errors++;
            $display("FAIL idle_writes got %0d want 0", wr_addr.size() - base);
        end
    endtask

    task automatic test_single_image();
        logic [7:0] img[$] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        logic [31:0] want[2] = '{32'h04030201, 32'h08070605};
        int base  = wr_addr.size();
        int abase = acc_cyc.size();
        int last;
        bit to, to2;
        pulse_start();
        send_bytes(img, 0, 7, 0, to);
        wait_done(to2);
        checks++;
        if (to || to2 || wr_addr.size() - base !== IMG_WORDS) begin
            errors++;
            $display("FAIL single_count got %0d writes (timeout=%b) want %0d", wr_addr.size() - base, to | to2, IMG_WORDS);
        end
        for (int w = 0; w < IMG_WORDS && base + w < wr_addr.size(); w++) begin
            checks++;
            if (wr_addr[base+w] !== ADDR_W'(BASE_ADDR + w) || wr_data[base+w] !== want[w] ||
                wr_flags[base+w] !== 3'b010) begin
                errors++;
                $display("FAIL single_word%0d got %h@%h flags=%b want %h@%h flags=010", w,
                         wr_data[base+w], wr_addr[base+w], wr_flags[base+w], want[w], ADDR_W'(BASE_ADDR + w));
            end
            if (abase + w < acc_cyc.size()) begin
                checks++;
                if (wr_cyc[base+w] !== acc_cyc[abase+w]) begin
                    errors++;
                    $display("FAIL single_latency%0d got write edge %0d want %0d", w, wr_cyc[base+w], acc_cyc[abase+w]);
                end
            end
        end
        last = wr_cyc.size() > 0 ? wr_cyc[wr_cyc.size()-1] : -100;
        checks++;
        if (done_rise_cyc !== last + 1 || proc_hold !== 1'b0 || done !== 1'b1 || word_count !== (ADDR_W+1)'(IMG_WORDS)) begin
            errors++;
            $display("FAIL single_done got rise=%0d hold=%b done=%b cnt=%0d want rise=%0d 0 1 %0d",
                     done_rise_cyc, proc_hold, done, word_count, last + 1, IMG_WORDS);
        end
        checks++;
        if (checksum !== exp_checksum(img)) begin
            errors++;
            $display("FAIL single_checksum got %h want %h", checksum, exp_checksum(img));
        end
        repeat (3) next_cycle();
        checks++;
        if (dmem_wren !== 1'b0 || dmem_addr !== ADDR_W'(BASE_ADDR + 1) || dmem_data !== want[1]) begin
            errors++;
            $display("FAIL single_hold got wren=%b %h@%h want 0 %h@%h", dmem_wren, dmem_data, dmem_addr,
                     want[1], ADDR_W'(BASE_ADDR + 1));
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] img[$];
        int base, abase, last;
        bit to, to2;
        for (int m = 1; m <= 2; m++) begin
            rand_image(img);
            base  = wr_addr.size();
            abase = acc_cyc.size();
            pulse_start();
            send_bytes(img, 0, 4 * IMG_WORDS - 1, m, to);
            wait_done(to2);
            checks++;
            if (to || to2 || wr_addr.size() - base !== IMG_WORDS) begin
                errors++;
                $display("FAIL bp%0d_count got %0d writes (timeout=%b) want %0d", m, wr_addr.size() - base, to | to2, IMG_WORDS);
            end
            for (int w = 0; w < IMG_WORDS && base + w < wr_addr.size(); w++) begin
                checks++;
                if (wr_addr[base+w] !== ADDR_W'(BASE_ADDR + w) || wr_data[base+w] !== word_of(img, w) ||
                    wr_flags[base+w] !== 3'b010) begin
                    errors++;
                    $display("FAIL bp%0d_word%0d got %h@%h flags=%b want %h@%h flags=010", m, w,
                             wr_data[base+w], wr_addr[base+w], wr_flags[base+w], word_of(img, w), ADDR_W'(BASE_ADDR + w));
                end
                if (abase + w < acc_cyc.size()) begin
                    checks++;
                    if (wr_cyc[base+w] !== acc_cyc[abase+w]) begin
                        errors++;
                        $display("FAIL bp%0d_latency%0d got write edge %0d want %0d", m, w, wr_cyc[base+w], acc_cyc[abase+w]);
                    end
                end
            end
            last = wr_cyc.size() > 0 ? wr_cyc[wr_cyc.size()-1] : -100;
            checks++;
            if (done_rise_cyc !== last + 1 || proc_hold !== 1'b0 || checksum !== exp_checksum(img)) begin
                errors++;
                $display("FAIL bp%0d_done got rise=%0d hold=%b sum=%h want rise=%0d hold=0 sum=%h",
                         m, done_rise_cyc, proc_hold, checksum, last + 1, exp_checksum(img));
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] img[$];
        int base;
        bit to, to2;
        rand_image(img);
        pulse_start();
        send_bytes(img, 0, 2, 0, to);
        base  = wr_addr.size();
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        repeat (3) next_cycle();
        checks++;
        if (to || wr_addr.size() !== base || in_ready !== 1'b0 || proc_hold !== 1'b1 ||
            done !== 1'b0 || word_count !== '0 || dmem_wren !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle got writes=%0d rdy=%b hold=%b done=%b cnt=%0d want 0 0 1 0 0",
                     wr_addr.size() - base, in_ready, proc_hold, done, word_count);
        end
        rand_image(img);
        pulse_start();
        send_bytes(img, 0, 4 * IMG_WORDS - 1, 2, to);
        wait_done(to2);
        checks++;
        if (to || to2 || wr_addr.size() - base !== IMG_WORDS) begin
            errors++;
            $display("FAIL midreset_count got %0d writes (timeout=%b) want %0d", wr_addr.size() - base, to | to2, IMG_WORDS);
        end
        for (int w = 0; w < IMG_WORDS && base + w < wr_addr.size(); w++) begin
            checks++;
            if (wr_addr[base+w] !== ADDR_W'(BASE_ADDR + w) || wr_data[base+w] !== word_of(img, w)) begin
                errors++;
                $display("FAIL midreset_word%0d got %h@%h want %h@%h", w, wr_data[base+w], wr_addr[base+w],
                         word_of(img, w), ADDR_W'(BASE_ADDR + w));
            end
        end
        next_cycle();
    endtask

    task automatic test_restart();
        logic [7:0] img[$];
        int base;
        bit to, to2, to3;
        for (int pass = 0; pass < 2; pass++) begin
            rand_image(img);
            base = wr_addr.size();
            pulse_start();
            checks++;
            if (done !== 1'b0 || proc_hold !== 1'b1 || word_count !== '0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL restart%0d_rearm got done=%b hold=%b cnt=%0d rdy=%b want 0 1 0 1",
                         pass, done, proc_hold, word_count, in_ready);
            end
            send_bytes(img, 0, 1, 0, to);
            pulse_start();   // ignored in LOAD
            send_bytes(img, 2, 4 * IMG_WORDS - 1, pass, to2);
            wait_done(to3);
            checks++;
            if (to || to2 || to3 || wr_addr.size() - base !== IMG_WORDS) begin
                errors++;
                $display("FAIL restart%0d_count got %0d writes (timeout=%b) want %0d", pass,
                         wr_addr.size() - base, to | to2 | to3, IMG_WORDS);
            end
            for (int w = 0; w < IMG_WORDS && base + w < wr_addr.size(); w++) begin
                checks++;
                if (wr_addr[base+w] !== ADDR_W'(BASE_ADDR + w) || wr_data[base+w] !== word_of(img, w)) begin
                    errors++;
                    $display("FAIL restart%0d_word%0d got %h@%h want %h@%h", pass, w, wr_data[base+w],
                             wr_addr[base+w], word_of(img, w), ADDR_W'(BASE_ADDR + w));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_checksum();
        logic [7:0] img[$] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
        logic [31:0] want;
        bit to, to2;
`ifdef IMAGE_LOADER_CHECKSUM_EN
        want = 32'h00000001;
`else
        want = 32'h00000000;
`endif
        pulse_start();
        send_bytes(img, 0, 7, 0, to);
        wait_done(to2);
        checks++;
        if (to || to2 || checksum !== want || word_count !== (ADDR_W+1)'(IMG_WORDS)) begin
            errors++;
            $display("FAIL checksum_wrap got sum=%h cnt=%0d (timeout=%b) want sum=%h cnt=%0d",
                     checksum, word_count, to | to2, want, IMG_WORDS);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_single_image();
        test_backpressure();
        test_reset_mid_word();
        test_restart();
        test_checksum();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
